trng_harvest: RTL and testbench
===============================

// Module: trng_harvest
// PURPOSE
//  Parametrised post-processing stage behind the ring-oscillator entropy unit.
//  - XOR-combines NUM_CH raw entropy bits.
//  - De-biases them with non-overlapping von Neumann pairs.
//  - Packs the surviving bits into WORD_W-bit words in a FIFO_DEPTH-entry FIFO.
//  - Delivers words over a valid/ready handshake; flags FIFO overflow.
//  - Optionally runs a repetition-count health test.
// PARAMETERS
//  NUM_CH     1   number of raw entropy inputs, XOR-combined per sample
//  WORD_W     8   output word width in bits (>=2)
//  FIFO_DEPTH 4   FIFO entries (power of 2, >=2)
//  RCT_LIMIT  16  identical consecutive samples that trip the alarm (>=2)
// PORTS
//  i_clk       in   1            system clock
//  i_rst_n     in   1            asynchronous reset, active low
//  i_sample_en in   1            strobe: sample i_raw this cycle
//  i_raw       in   NUM_CH       raw bits (already synchronised)
//  i_enable    in   1            harvesting enable
//  i_clear     in   1            synchronous flush of all state and flags
//  i_ready     in   1            consumer accepts o_data this cycle
//  o_valid     out  1            FIFO non-empty
//  o_data      out  WORD_W       FIFO head word
//  o_count     out  clog2(D+1)   words stored in the FIFO
//  o_overflow  out  1            sticky: a completed word was dropped
//  o_alarm     out  1            sticky: health-test failure
// BEHAVIOUR
//  - Reset: single clock i_clk; async active-low i_rst_n.
//    All outputs, FIFO pointers, pair state, shift register and counters go to 0.
//  - Sample: s = ^i_raw, taken on edges where i_sample_en & i_enable.
//  - Pair FSM: EMPTY -> HAVE_FIRST on the first sample (store b0).
//    HAVE_FIRST -> EMPTY on the second sample b1:
//      b0!=b1: emit bit b0 (so 10 -> 1, 01 -> 0); b0==b1: discard the pair.
//  - Packer: an emitted bit shifts into bit 0, older bits move left.
//    A bit counter counts 0..WORD_W-1.
//  - Word push: on the edge accepting the WORD_W-th bit, {sh[WORD_W-2:0],bit} is
//    written to the FIFO tail on that same edge and the counter returns to 0.
//    First-harvested bit ends up in the MSB.
//  - Full FIFO at push with no pop that cycle: word dropped, o_overflow<=1, counter
//    still returns to 0. Full FIFO with a pop on the same edge: push accepted,
//    o_count unchanged, no overflow.
//  - Output: o_valid=(o_count!=0); o_data=head, registered FIFO storage, no bypass.
//    A word written at edge N is visible at o_data/o_valid after edge N.
//    Pop on edges with o_valid & i_ready. Pop while empty is ignored.
//  - i_enable=0: pair FSM -> EMPTY, partial word and bit counter cleared.
//    FIFO, pop path and flags are retained.
//  - i_clear=1: same effect as reset on the next edge (FIFO emptied, flags cleared).
//    i_clear overrides any simultaneous push or pop.
//  - Reset asserted mid-operation: everything clears immediately, no partial
//    word survives.
//  - o_count: same width arithmetic as the pointers, which are clog2(D)+1 bits
//    and wrap.
// CONFIGURATION
//  TRNG_HEALTH_EN defined:
//    - Repetition counter on s increments when s equals the previous sample, else
//      reloads to 1.
//    - When it reaches RCT_LIMIT, o_alarm<=1 on that edge and the partial word is
//      discarded.
//    - While o_alarm=1 no pair/packer activity occurs and no FIFO pushes happen.
//      Pops continue.
//    - Only i_clear or reset releases the alarm.
//  TRNG_HEALTH_EN undefined: o_alarm tied 0; no counter is synthesised.
// TESTING
//  - WORD_W=8: 8 pairs "10" (16 strobes) -> one push, o_data=8'hFF, o_count=1.
//    8 pairs "01" -> o_data=8'h00.
//  - Discard: 4 pairs "00", 4 pairs "11", then 8 pairs "10" -> exactly one word
//    8'hFF; no push after the first 8 pairs.
//  - Order: harvest bits 1,0,1,1,0,0,1,0 via pairs -> o_data=8'hB2.
//  - Overflow: i_ready=0, 5 words with FIFO_DEPTH=4 -> o_count=4, o_overflow=1.
//    Then draining with i_ready=1 returns words 1-4 in order, o_valid falls after
//    the 4th pop.
//  - Full FIFO with push and pop on the same edge -> o_count stays 4, o_overflow
//    stays 0, head advances.
//  - TRNG_HEALTH_EN, RCT_LIMIT=16: 16 strobes of s=1 -> o_alarm=1 at the 16th edge,
//    no pushes afterwards. i_clear -> o_alarm=0, o_count=0.
//  - Reset: assert i_rst_n low mid-word with o_count=2 -> all outputs 0 without a
//    clock edge. The next full word after release is clean.

Source files
------------

// File: rtl/trng_harvest.sv
// trng_harvest: post-processing behind the ring-oscillator entropy unit.
// Raw bits are XOR-combined, de-biased with von Neumann pairs, packed MSB-first
// into WORD_W-bit words and queued in a FIFO_DEPTH-entry FIFO with a
// valid/ready read side and a sticky overflow flag.
// Optional feature: define TRNG_HEALTH_EN to add a repetition-count health test
// that raises a sticky o_alarm and freezes harvesting until i_clear or reset.
module trng_harvest #(
  parameter int NUM_CH     = 1,
  parameter int WORD_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int RCT_LIMIT  = 16
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst_n,
  input  logic                                  i_sample_en,
  input  logic [NUM_CH-1:0]                     i_raw,
  input  logic                                  i_enable,
  input  logic                                  i_clear,
  input  logic                                  i_ready,
  output logic                                  o_valid,
  output logic [WORD_W-1:0]                     o_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]       o_count,
  output logic                                  o_overflow,
  output logic                                  o_alarm
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(WORD_W);

  typedef enum logic {
    ST_EMPTY      = 1'b0,
    ST_HAVE_FIRST = 1'b1
  } pair_t;

  // Combined sample bit of all raw channels.
  function automatic logic parity(input logic [NUM_CH-1:0] v);
    return ^v;
  endfunction

  pair_t              pair_r;
  logic               b0_r;
  logic [WORD_W-2:0]  sh_r;
  logic [CW-1:0]      bcnt_r;

  logic [WORD_W-1:0]  mem_r [FIFO_DEPTH];
  logic [PW-1:0]      wr_r;
  logic [PW-1:0]      rd_r;
  logic [PW-1:0]      count_r;
  logic               valid_r;
  logic [WORD_W-1:0]  data_r;
  logic               ovf_r;

  logic               s_s;
  logic               samp_s;
  logic               take_s;
  logic               emit_s;
  logic [WORD_W-1:0]  cat_s;
  logic               last_bit_s;
  logic               push_req_s;
  logic               full_s;
  logic               pop_s;
  logic               push_ok_s;
  logic               drop_s;
  logic [PW-1:0]      wr_nx_s;
  logic [PW-1:0]      rd_nx_s;
  logic [PW-1:0]      count_nx_s;
  logic [WORD_W-1:0]  head_nx_s;
  logic               alarm_s;
  logic               trip_s;

`ifdef TRNG_HEALTH_EN
  localparam int RW = $clog2(RCT_LIMIT + 1);

  logic [RW-1:0]      rct_r;
  logic               last_r;
  logic               alarm_r;
  logic [RW-1:0]      rct_nx_s;

  // Repetition count of the combined sample and the trip condition.
  always_comb begin
    rct_nx_s = RW'(1);
    if ((rct_r != '0) && (s_s == last_r)) begin
      rct_nx_s = rct_r + RW'(1);
    end else begin
      rct_nx_s = RW'(1);
    end
    trip_s = samp_s & ~alarm_r & (rct_nx_s == RW'(RCT_LIMIT));
  end

  // Health-test state: run length, previous sample and sticky alarm.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rct_r   <= '0;
      last_r  <= 1'b0;
      alarm_r <= 1'b0;
    end else if (i_clear) begin
      rct_r   <= '0;
      last_r  <= 1'b0;
      alarm_r <= 1'b0;
    end else if (samp_s && !alarm_r) begin
      rct_r  <= rct_nx_s;
      last_r <= s_s;
      if (trip_s) begin
        alarm_r <= 1'b1;
      end
    end
  end

  assign alarm_s = alarm_r;
  assign o_alarm = alarm_r;
`else
  assign alarm_s = 1'b0;
  assign trip_s  = 1'b0;
  assign o_alarm = 1'b0;
`endif

  // Sample qualification, word completion and FIFO next-state arithmetic.
  always_comb begin
    s_s        = parity(i_raw);
    samp_s     = i_sample_en & i_enable;
    take_s     = samp_s & ~alarm_s;
    emit_s     = take_s & (pair_r == ST_HAVE_FIRST) & (b0_r != s_s);
    cat_s      = {sh_r, b0_r};
    last_bit_s = (bcnt_r == CW'(WORD_W - 1));
    push_req_s = emit_s & last_bit_s & ~trip_s;
    full_s     = (count_r == PW'(FIFO_DEPTH));
    pop_s      = valid_r & i_ready;
    push_ok_s  = push_req_s & (~full_s | pop_s);
    drop_s     = push_req_s & full_s & ~pop_s;
    wr_nx_s    = wr_r + PW'(push_ok_s);
    rd_nx_s    = rd_r + PW'(pop_s);
    count_nx_s = wr_nx_s - rd_nx_s;
    head_nx_s  = '0;
    if (push_ok_s && (wr_r[AW-1:0] == rd_nx_s[AW-1:0])) begin
      head_nx_s = cat_s;
    end else begin
      head_nx_s = mem_r[rd_nx_s[AW-1:0]];
    end
  end

  // Von Neumann pair FSM and bit packer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pair_r <= ST_EMPTY;
      b0_r   <= 1'b0;
      sh_r   <= '0;
      bcnt_r <= '0;
    end else if (i_clear || !i_enable || trip_s) begin
      pair_r <= ST_EMPTY;
      b0_r   <= 1'b0;
      sh_r   <= '0;
      bcnt_r <= '0;
    end else if (take_s) begin
      case (pair_r)
        ST_EMPTY: begin
          pair_r <= ST_HAVE_FIRST;
          b0_r   <= s_s;
        end
        ST_HAVE_FIRST: begin
          pair_r <= ST_EMPTY;
          if (emit_s) begin
            if (last_bit_s) begin
              bcnt_r <= '0;
              sh_r   <= '0;
            end else begin
              bcnt_r <= bcnt_r + CW'(1);
              sh_r   <= cat_s[WORD_W-2:0];
            end
          end
        end
        default: begin
          pair_r <= ST_EMPTY;
        end
      endcase
    end
  end

  // FIFO storage write port; contents are only meaningful between the pointers.
  always_ff @(posedge i_clk) begin
    if (push_ok_s && !i_clear) begin
      mem_r[wr_r[AW-1:0]] <= cat_s;
    end
  end

  // FIFO pointers, registered head word, count, valid and sticky overflow.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_r    <= '0;
      rd_r    <= '0;
      count_r <= '0;
      valid_r <= 1'b0;
      data_r  <= '0;
      ovf_r   <= 1'b0;
    end else if (i_clear) begin
      wr_r    <= '0;
      rd_r    <= '0;
      count_r <= '0;
      valid_r <= 1'b0;
      data_r  <= '0;
      ovf_r   <= 1'b0;
    end else begin
      wr_r    <= wr_nx_s;
      rd_r    <= rd_nx_s;
      count_r <= count_nx_s;
      valid_r <= (count_nx_s != '0);
      data_r  <= head_nx_s;
      if (drop_s) begin
        ovf_r <= 1'b1;
      end
    end
  end

  assign o_valid    = valid_r;
  assign o_data     = data_r;
  assign o_count    = count_r;
  assign o_overflow = ovf_r;

endmodule

// File: tb/tb_trng_harvest.sv
// Self-checking bench for trng_harvest with default parameters. A queue-based
// model of harvesting and the FIFO is compared against the outputs every cycle;
// directed sequences add hand-computed expectations.
module tb_trng_harvest;

  localparam int NUM_CH     = 1;
  localparam int WORD_W     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int RCT_LIMIT  = 16;

  logic                  i_clk = 1'b0;
  logic                  i_rst_n = 1'b0;
  logic                  i_sample_en = 1'b0;
  logic [NUM_CH-1:0]     i_raw = '0;
  logic                  i_enable = 1'b1;
  logic                  i_clear = 1'b0;
  logic                  i_ready = 1'b0;
  logic                  o_valid;
  logic [WORD_W-1:0]     o_data;
  logic [$clog2(FIFO_DEPTH+1)-1:0] o_count;
  logic                  o_overflow;
  logic                  o_alarm;

  int n_chk = 0;
  int n_fail = 0;

  trng_harvest #(
    .NUM_CH(NUM_CH), .WORD_W(WORD_W), .FIFO_DEPTH(FIFO_DEPTH), .RCT_LIMIT(RCT_LIMIT)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_sample_en(i_sample_en), .i_raw(i_raw),
    .i_enable(i_enable), .i_clear(i_clear), .i_ready(i_ready), .o_valid(o_valid),
    .o_data(o_data), .o_count(o_count), .o_overflow(o_overflow), .o_alarm(o_alarm)
  );

  always #5 i_clk = ~i_clk;

  // ---------------- behavioural model ----------------
  bit [WORD_W-1:0] m_q[$];
  bit              m_bits[$];
  bit              m_have_first = 1'b0;
  bit              m_b0 = 1'b0;
  bit              m_ovf = 1'b0;
  bit              m_alarm = 1'b0;
  bit              m_have_prev = 1'b0;
  bit              m_prev = 1'b0;
  int              m_run = 0;

  task automatic m_reset();
    m_q.delete();
    m_bits.delete();
    m_have_first = 1'b0;
    m_b0 = 1'b0;
    m_ovf = 1'b0;
    m_alarm = 1'b0;
    m_have_prev = 1'b0;
    m_prev = 1'b0;
    m_run = 0;
  endtask

  task automatic m_step();
    int size0;
    bit do_pop;
    bit word_ready;
    bit trip;
    bit s;
    bit [WORD_W-1:0] w;
    size0 = m_q.size();
    do_pop = (size0 != 0) && i_ready;
    word_ready = 1'b0;
    trip = 1'b0;
    s = ^i_raw;
    w = '0;
    if (!i_enable) begin
      m_have_first = 1'b0;
      m_bits.delete();
    end else if (i_sample_en && !m_alarm) begin
`ifdef TRNG_HEALTH_EN
      if (m_have_prev && s == m_prev) m_run = m_run + 1;
      else m_run = 1;
      m_prev = s;
      m_have_prev = 1'b1;
      if (m_run == RCT_LIMIT) begin
        m_alarm = 1'b1;
        trip = 1'b1;
        m_have_first = 1'b0;
        m_bits.delete();
      end
`endif
      if (!trip) begin
        if (!m_have_first) begin
          m_have_first = 1'b1;
          m_b0 = s;
        end else begin
          m_have_first = 1'b0;
          if (m_b0 != s) m_bits.push_back(m_b0);
          if (m_bits.size() == WORD_W) begin
            foreach (m_bits[i]) w = {w[WORD_W-2:0], m_bits[i]};
            m_bits.delete();
            word_ready = 1'b1;
          end
        end
      end
    end
    if (do_pop) void'(m_q.pop_front());
    if (word_ready) begin
      if (size0 == FIFO_DEPTH && !do_pop) m_ovf = 1'b1;
      else m_q.push_back(w);
    end
  endtask

  // Model advances on each active edge and clears at once on reset.
  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) m_reset();
    else if (i_clear) m_reset();
    else m_step();
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge i_clk) begin
    check("valid", 32'(o_valid), 32'(m_q.size() != 0));
    check("count", 32'(o_count), 32'(m_q.size()));
    if (m_q.size() != 0) check("data", 32'(o_data), 32'(m_q[0]));
    check("overflow", 32'(o_overflow), 32'(m_ovf));
    check("alarm", 32'(o_alarm), 32'(m_alarm));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input bit se, input bit s);
    logic [NUM_CH-1:0] r;
    r = NUM_CH'($urandom);
    if ((^r) != s) r[0] = ~r[0];
    i_sample_en = se;
    i_raw = r;
    @(negedge i_clk);
    i_sample_en = 1'b0;
  endtask

  task automatic send_word(input logic [WORD_W-1:0] w, input bit pop_last);
    bit b;
    for (int i = WORD_W - 1; i >= 0; i--) begin
      b = w[i];
      tick(1'b1, b);
      if (i == 0 && pop_last) i_ready = 1'b1;
      tick(1'b1, ~b);
      if (i == 0 && pop_last) i_ready = 1'b0;
      if ($urandom_range(0, 3) == 0) tick(1'b0, 1'b0);
    end
  endtask

  task automatic do_clear();
    i_clear = 1'b1;
    tick(1'b0, 1'b0);
    i_clear = 1'b0;
  endtask

  task automatic drain();
    i_ready = 1'b1;
    repeat (FIFO_DEPTH + 1) tick(1'b0, 1'b0);
    i_ready = 1'b0;
  endtask

  logic [WORD_W-1:0] ovf_words [5];

  initial begin
    ovf_words[0] = 8'hA1; ovf_words[1] = 8'h52; ovf_words[2] = 8'hC3;
    ovf_words[3] = 8'h34; ovf_words[4] = 8'hE5;

    repeat (3) @(negedge i_clk);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_count", 32'(o_count), 32'd0);
    check("rst_ovf", 32'(o_overflow), 32'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // 8 pairs "10" -> 0xFF, then 8 pairs "01" -> 0x00
    send_word(8'hFF, 1'b0);
    check("ones_count", 32'(o_count), 32'd1);
    check("ones_data", 32'(o_data), 32'hFF);
    drain();
    send_word(8'h00, 1'b0);
    check("zeros_data", 32'(o_data), 32'h00);
    check("zeros_valid", 32'(o_valid), 32'd1);
    drain();

    // equal pairs are discarded
    repeat (4) begin tick(1'b1, 1'b0); tick(1'b1, 1'b0); end
    repeat (4) begin tick(1'b1, 1'b1); tick(1'b1, 1'b1); end
    check("discard_count", 32'(o_count), 32'd0);
    send_word(8'hFF, 1'b0);
    check("discard_then_count", 32'(o_count), 32'd1);
    check("discard_then_data", 32'(o_data), 32'hFF);
    drain();

    // bit order: 1,0,1,1,0,0,1,0 -> 0xB2
    send_word(8'hB2, 1'b0);
    check("order_data", 32'(o_data), 32'hB2);
    drain();

    // overflow: five words into a four-entry FIFO
    for (int k = 0; k < 5; k++) send_word(ovf_words[k], 1'b0);
    check("ovf_count", 32'(o_count), 32'd4);
    check("ovf_flag", 32'(o_overflow), 32'd1);
    for (int k = 0; k < 4; k++) begin
      check("drain_data", 32'(o_data), 32'(ovf_words[k]));
      i_ready = 1'b1;
      tick(1'b0, 1'b0);
      i_ready = 1'b0;
    end
    check("drain_valid", 32'(o_valid), 32'd0);
    check("ovf_sticky", 32'(o_overflow), 32'd1);
    do_clear();
    check("clear_ovf", 32'(o_overflow), 32'd0);

    // full FIFO with push and pop on the same edge
    send_word(8'h11, 1'b0); send_word(8'h22, 1'b0);
    send_word(8'h33, 1'b0); send_word(8'h44, 1'b0);
    send_word(8'h55, 1'b1);
    check("pp_count", 32'(o_count), 32'd4);
    check("pp_ovf", 32'(o_overflow), 32'd0);
    check("pp_head", 32'(o_data), 32'h22);
    drain();

    // enable low drops a half pair and a partial word
    tick(1'b1, 1'b1); tick(1'b1, 1'b0); tick(1'b1, 1'b1); tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    i_enable = 1'b0; tick(1'b0, 1'b0); i_enable = 1'b1;
    send_word(8'h3C, 1'b0);
    check("enable_count", 32'(o_count), 32'd1);
    check("enable_data", 32'(o_data), 32'h3C);
    drain();

    // repetition test
    do_clear();
    repeat (RCT_LIMIT - 1) tick(1'b1, 1'b1);
    check("rct_before", 32'(o_alarm), 32'd0);
    tick(1'b1, 1'b1);
`ifdef TRNG_HEALTH_EN
    check("rct_alarm", 32'(o_alarm), 32'd1);
    send_word(8'hFF, 1'b0);
    check("rct_nopush", 32'(o_count), 32'd0);
`else
    check("rct_off", 32'(o_alarm), 32'd0);
    check("rct_off_count", 32'(o_count), 32'd0);
`endif
    do_clear();
    check("rct_clear_alarm", 32'(o_alarm), 32'd0);
    check("rct_clear_count", 32'(o_count), 32'd0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      i_ready  = (c < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      i_enable = ($urandom_range(0, 31) != 0);
      i_clear  = ($urandom_range(0, 399) == 0);
      tick(1'($urandom), 1'($urandom));
      i_clear  = 1'b0;
    end
    i_enable = 1'b1;
    i_ready = 1'b0;

    // asynchronous reset mid-word with two words stored
    do_clear();
    send_word(8'hA5, 1'b0);
    send_word(8'h5A, 1'b0);
    tick(1'b1, 1'b1); tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b1, 1'b1);
    check("pre_rst_count", 32'(o_count), 32'd2);
    #2 i_rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(o_valid), 32'd0);
    check("arst_data", 32'(o_data), 32'd0);
    check("arst_count", 32'(o_count), 32'd0);
    check("arst_ovf", 32'(o_overflow), 32'd0);
    check("arst_alarm", 32'(o_alarm), 32'd0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    send_word(8'hC6, 1'b0);
    check("post_rst_count", 32'(o_count), 32'd1);
    check("post_rst_data", 32'(o_data), 32'hC6);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
